icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, one-word-per-block instruction cache; the responder for the datapath's imem request port.
//  Datapath presents imemREN/imemaddr and receives ihit/imemload the same cycle on a hit.
//  On a miss it fetches the word from the memory controller (iREN/iaddr/iwait/iload), fills the frame, then hits.
//  Sits between the pipelined datapath and the memory arbiter.
// PARAMETERS
//  NSETS    16   number of frames; power of two, >=2; IDXW = $clog2(NSETS)
// PORTS
//  CLK       in   1   clock; all state updates on posedge
//  nRST      in   1   reset, synchronous, active-low
//  imemREN   in   1   datapath instruction read request
//  imemaddr  in   32  instruction byte address; bits[1:0] ignored
//  ihit      out  1   imemload valid for imemaddr this cycle
//  imemload  out  32  instruction word
//  iREN      out  1   memory read request
//  iaddr     out  32  memory word address, bits[1:0] = 00
//  iwait     in   1   memory busy; iload valid in the cycle iwait=0 while iREN=1
//  iload     in   32  memory read data
// BEHAVIOUR
//  Address split: idx = addr[IDXW+1:2]; tag = addr[31:IDXW+2].
//  Frame = {valid, tag, data}. Reset (nRST=0 at posedge): every valid<=0, state<=IDLE, miss_addr<=0; outputs
//   are then ihit=0, iREN=0, iaddr=0, imemload=frame data (don't-care while ihit=0).
//  FSM IDLE:
//   ihit = imemREN & valid[idx] & (tag[idx]==tag), combinational, 0-cycle hit latency; imemload = data[idx].
//   imemREN & !ihit -> latch miss_addr = {imemaddr[31:2],2'b00}; go FILL. iREN=0 in IDLE.
//  FSM FILL:
//   iREN=1, iaddr=miss_addr, ihit=0. iwait=1 -> stay. iwait=0 -> write frame[miss idx] = {1, miss tag, iload};
//   go IDLE. Next cycle the request hits if imemaddr is unchanged. Miss latency = memory latency + 1 cycle.
//  Boundary cases:
//   imemaddr changes or imemREN drops during FILL (branch/jump redirect): fill still completes for miss_addr;
//    IDLE re-evaluates the new address afterward. No abort.
//   Fill overwrites a valid frame with a different tag (conflict): old entry lost; no writeback.
//   Reset mid-FILL: iREN drops the next cycle and no frame is written. The memory side must tolerate
//    an abandoned request.
//   imemREN=0 in IDLE: ihit=0, no state change.
//   Address with bits[1:0]!=0: treated as the aligned word.
// CONFIGURATION
//  `ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], both 0 at reset.
//   hit_count increments on every cycle with ihit=1.
//   miss_count increments on every IDLE->FILL transition.
//   Both wrap modulo 2^32.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  cpu_types_pkg supplies word_t.
//  caches_pkg (shared with the future dcache) holds:
//   icache_state_t enum {IDLE, FILL}
//   icachef_t packed {tag, idx, bytoff} address view
//   icache_frame_t {valid, tag, data}
//  The frame array and FSM are inline; no sub-module is needed.
//  Stats counters form a generate-free `ifdef block in the same file.
// TESTING
//  1 Reset, then imemREN=1, imemaddr=0x0000_0040 -> ihit=0, iREN=1, iaddr=0x40.
//    iwait=1 for 3 cycles, then iwait=0 with iload=0xDEAD_BEEF -> next cycle ihit=1, imemload=0xDEADBEEF, iREN=0.
//  2 Repeat request 0x40 -> ihit=1 in the same cycle with no iREN.
//    Request 0x44 -> miss to idx 1; frame idx 0 is unaffected.
//  3 Conflict, NSETS=16: fill 0x40 (idx0), then request 0x80 (same idx, tag differs) -> miss.
//    After the fill, 0x40 misses again.
//  4 Redirect mid-FILL: miss on 0x100, change imemaddr to 0x200 before iwait=0.
//    -> frame for 0x100 is filled; then iREN=1, iaddr=0x200.
//  5 Assert nRST=0 during FILL -> iREN=0 next cycle; after reset 0x40 misses again.
//  6 With `ICACHE_STATS_EN, run scenario 1 then 2 hit cycles -> miss_count=1, hit_count=3.

Source files
------------

// File: rtl/icache_dm_pkg.sv
// Shared cache types: word, FSM state, address view and frame layout for the default geometry.
package icache_dm_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } icache_state_t;

   localparam int unsigned ICACHE_IDXW = 4;

   typedef struct packed {
      logic [31-ICACHE_IDXW-2:0] tag;
      logic [ICACHE_IDXW-1:0]    idx;
      logic [1:0]                bytoff;
   } icachef_t;

   typedef struct packed {
      logic                      valid;
      logic [31-ICACHE_IDXW-2:0] tag;
      word_t                     data;
   } icache_frame_t;

   function automatic word_t word_align(word_t a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Datapath imem port plus memory-controller read port seen by the instruction cache.
interface icache_dm_if;
   import icache_dm_pkg::*;

   logic  imemREN;
   word_t imemaddr;
   logic  ihit;
   word_t imemload;
   logic  iREN;
   word_t iaddr;
   logic  iwait;
   word_t iload;

   modport slave (
      input  imemREN, imemaddr, iwait, iload,
      output ihit, imemload, iREN, iaddr
   );

   modport master (
      output imemREN, imemaddr, iwait, iload,
      input  ihit, imemload, iREN, iaddr
   );

endinterface

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-cycle hits and blocking fills.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_dm
   import icache_dm_pkg::*;
#(
   parameter int unsigned NSETS = 16
) (
   input  logic       CLK,
   input  logic       nRST,
   icache_dm_if.slave bus
`ifdef ICACHE_STATS_EN
   ,
   output word_t      hit_count,
   output word_t      miss_count
`endif
);

   localparam int unsigned IDXW = $clog2(NSETS);
   localparam int unsigned TAGW = 30 - IDXW;

   logic [NSETS-1:0] valid_q;
   logic [TAGW-1:0]  tag_q  [NSETS];
   word_t            data_q [NSETS];

   icache_state_t    state_q;
   word_t            miss_addr_q;

   logic [IDXW-1:0]  req_idx;
   logic [IDXW-1:0]  miss_idx;
   logic [TAGW-1:0]  req_tag;
   logic [TAGW-1:0]  miss_tag;
   logic             hit;
   logic             miss;
   logic             unused_bytoff;

   assign req_idx       = bus.imemaddr[IDXW+1:2];
   assign req_tag       = bus.imemaddr[31:IDXW+2];
   assign miss_idx      = miss_addr_q[IDXW+1:2];
   assign miss_tag      = miss_addr_q[31:IDXW+2];
   assign unused_bytoff = ^{bus.imemaddr[1:0], miss_addr_q[1:0]};

   always_comb begin
      hit  = 1'b0;
      miss = 1'b0;
      if (state_q == IDLE && bus.imemREN) begin
         hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
         miss = !hit;
      end
   end

   assign bus.ihit     = hit;
   assign bus.imemload = data_q[req_idx];
   assign bus.iREN     = (state_q == FILL);
   assign bus.iaddr    = miss_addr_q;

   // A fill always completes for the latched miss address, even if the datapath redirects.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         miss_addr_q <= '0;
         valid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (miss) begin
                  miss_addr_q <= word_align(bus.imemaddr);
                  state_q     <= FILL;
               end
            end
            FILL: begin
               if (!bus.iwait) begin
                  valid_q[miss_idx] <= 1'b1;
                  tag_q[miss_idx]   <= miss_tag;
                  data_q[miss_idx]  <= bus.iload;
                  state_q           <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   word_t hit_cnt_q;
   word_t miss_cnt_q;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized traffic against a set-indexed model.
module tb_icache_dm;
   import icache_dm_pkg::*;

   localparam int unsigned NS = 16;

   logic clk = 1'b0;
   logic nRST;
   always #5 clk = ~clk;

   icache_dm_if bus();

`ifdef ICACHE_STATS_EN
   word_t hit_count;
   word_t miss_count;
`endif

   icache_dm #(.NSETS(NS)) dut (
      .CLK   (clk),
      .nRST  (nRST),
      .bus   (bus)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Model: which aligned word address each set currently holds, and its data.
   bit    mv [NS];
   word_t ma [NS];
   word_t md [NS];

   function automatic word_t mem_word(word_t a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int unsigned set_of(word_t a);
      return (a / 4) % NS;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      foreach (mv[i]) mv[i] = 1'b0;
   endtask

   task automatic model_fill(input word_t a, input word_t d);
      mv[set_of(a)] = 1'b1;
      ma[set_of(a)] = a & ~32'h3;
      md[set_of(a)] = d;
   endtask

   task automatic apply_reset();
      nRST = 1'b0;
      bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iwait = 1'b1; bus.iload = '0;
      tick(); tick();
      nRST = 1'b1;
      model_clear();
   endtask

   // Caller sits in the first FILL cycle; holds iwait for lat cycles then returns data.
   task automatic serve(input int unsigned lat, input word_t d);
      repeat (lat) begin
         bus.iwait = 1'b1;
         tick();
      end
      bus.iwait = 1'b0;
      bus.iload = d;
      tick();
      bus.iwait = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b1; bus.iload = '0;
      tick(); tick();
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got %b exp 0", bus.ihit); end
      checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN got %b exp 0", bus.iREN); end
      checks++; if (bus.iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got %h exp 0", bus.iaddr); end
`ifdef ICACHE_STATS_EN
      checks++; if (hit_count !== 32'h0) begin errors++; $display("FAIL reset_hit_count got %0d exp 0", hit_count); end
      checks++; if (miss_count !== 32'h0) begin errors++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
`endif
      nRST = 1'b1;
      bus.imemREN = 1'b0;
      model_clear();
      tick();
   endtask

   task automatic test_first_miss();
      bus.imemREN = 1'b1; bus.imemaddr = 32'h40; bus.iwait = 1'b1;
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s1_cold_ihit got %b exp 0", bus.ihit); end
      checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL s1_idle_iREN got %b exp 0", bus.iREN); end
      tick();
      checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL s1_fill_iREN got %b exp 1", bus.iREN); end
      checks++; if (bus.iaddr !== 32'h40) begin errors++; $display("FAIL s1_fill_iaddr got %h exp 40", bus.iaddr); end
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s1_fill_ihit got %b exp 0", bus.ihit); end
      tick(); tick();
      checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL s1_wait_iREN got %b exp 1", bus.iREN); end
      bus.iwait = 1'b0; bus.iload = 32'hDEAD_BEEF;
      tick();
      bus.iwait = 1'b1;
      model_fill(32'h40, 32'hDEAD_BEEF);
      #1;
      checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL s1_after_fill_ihit got %b exp 1", bus.ihit); end
      checks++; if (bus.imemload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL s1_after_fill_data got %h exp deadbeef", bus.imemload); end
      checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL s1_after_fill_iREN got %b exp 0", bus.iREN); end
      tick();
   endtask

   task automatic test_hit_and_neighbour();
      bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
      #1;
      checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL s2_rehit got %b exp 1", bus.ihit); end
      checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL s2_rehit_iREN got %b exp 0", bus.iREN); end
      tick();
      bus.imemaddr = 32'h44;
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s2_idx1_ihit got %b exp 0", bus.ihit); end
      tick();
      checks++; if (bus.iaddr !== 32'h44) begin errors++; $display("FAIL s2_idx1_iaddr got %h exp 44", bus.iaddr); end
      serve(1, 32'h0000_0444);
      model_fill(32'h44, 32'h0000_0444);
      #1;
      checks++; if (bus.imemload !== 32'h0000_0444 || bus.ihit !== 1'b1) begin errors++; $display("FAIL s2_idx1_hit got %b/%h exp 1/444", bus.ihit, bus.imemload); end
      bus.imemaddr = 32'h42;
      #1;
      checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL s2_idx0_kept got %b/%h exp 1/deadbeef", bus.ihit, bus.imemload); end
      tick();
   endtask

   task automatic test_conflict();
      bus.imemREN = 1'b1; bus.imemaddr = 32'h80;
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s3_conflict_ihit got %b exp 0", bus.ihit); end
      tick();
      checks++; if (bus.iaddr !== 32'h80) begin errors++; $display("FAIL s3_conflict_iaddr got %h exp 80", bus.iaddr); end
      serve(1, 32'hCAFE_0080);
      model_fill(32'h80, 32'hCAFE_0080);
      #1;
      checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hCAFE_0080) begin errors++; $display("FAIL s3_new_hit got %b/%h exp 1/cafe0080", bus.ihit, bus.imemload); end
      bus.imemaddr = 32'h40;
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s3_evicted got %b exp 0", bus.ihit); end
      tick();
      checks++; if (bus.iaddr !== 32'h40) begin errors++; $display("FAIL s3_refill_iaddr got %h exp 40", bus.iaddr); end
      serve(0, 32'hDEAD_BEEF);
      model_fill(32'h40, 32'hDEAD_BEEF);
      #1;
      checks++; if (bus.ihit !== 1'b1) begin errors++; $display("FAIL s3_refill_hit got %b exp 1", bus.ihit); end
      tick();
   endtask

   task automatic test_redirect();
      bus.imemREN = 1'b1; bus.imemaddr = 32'h100;
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s4_miss got %b exp 0", bus.ihit); end
      tick();
      bus.imemaddr = 32'h200;
      #1;
      checks++; if (bus.iaddr !== 32'h100 || bus.ihit !== 1'b0) begin errors++; $display("FAIL s4_hold_iaddr got %h/%b exp 100/0", bus.iaddr, bus.ihit); end
      tick();
      checks++; if (bus.iaddr !== 32'h100 || bus.iREN !== 1'b1) begin errors++; $display("FAIL s4_hold2_iaddr got %h/%b exp 100/1", bus.iaddr, bus.iREN); end
      bus.iwait = 1'b0; bus.iload = 32'h1000_0100;
      tick();
      bus.iwait = 1'b1;
      model_fill(32'h100, 32'h1000_0100);
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s4_new_addr_miss got %b exp 0", bus.ihit); end
      bus.imemaddr = 32'h100;
      #1;
      checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h1000_0100) begin errors++; $display("FAIL s4_old_filled got %b/%h exp 1/10000100", bus.ihit, bus.imemload); end
      bus.imemaddr = 32'h200;
      tick();
      checks++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h200) begin errors++; $display("FAIL s4_second_fill got %b/%h exp 1/200", bus.iREN, bus.iaddr); end
      serve(2, 32'h2000_0200);
      model_fill(32'h200, 32'h2000_0200);
      #1;
      checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'h2000_0200) begin errors++; $display("FAIL s4_second_hit got %b/%h exp 1/20000200", bus.ihit, bus.imemload); end
      tick();
   endtask

   task automatic test_reset_mid_fill();
      bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s5_miss got %b exp 0", bus.ihit); end
      tick();
      checks++; if (bus.iREN !== 1'b1) begin errors++; $display("FAIL s5_fill_iREN got %b exp 1", bus.iREN); end
      nRST = 1'b0; bus.iwait = 1'b0; bus.iload = 32'h1111_1111;
      tick();
      checks++; if (bus.iREN !== 1'b0) begin errors++; $display("FAIL s5_abort_iREN got %b exp 0", bus.iREN); end
      nRST = 1'b1; bus.iwait = 1'b1;
      model_clear();
      #1;
      checks++; if (bus.ihit !== 1'b0) begin errors++; $display("FAIL s5_no_write got %b exp 0", bus.ihit); end
      tick();
      checks++; if (bus.iREN !== 1'b1 || bus.iaddr !== 32'h40) begin errors++; $display("FAIL s5_refetch got %b/%h exp 1/40", bus.iREN, bus.iaddr); end
      serve(0, 32'hDEAD_BEEF);
      model_fill(32'h40, 32'hDEAD_BEEF);
      #1;
      checks++; if (bus.ihit !== 1'b1 || bus.imemload !== 32'hDEAD_BEEF) begin errors++; $display("FAIL s5_refetch_hit got %b/%h exp 1/deadbeef", bus.ihit, bus.imemload); end
      tick();
   endtask

   task automatic test_random();
      word_t       a;
      word_t       al;
      int unsigned s;
      bit          exp_hit;
      int unsigned lat;
      int unsigned exp_hits = 0;
      int unsigned exp_miss = 0;
      apply_reset();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            bus.imemREN = 1'b0; bus.imemaddr = $urandom;
            #1;
            checks++; if (bus.ihit !== 1'b0 || bus.iREN !== 1'b0) begin errors++; $display("FAIL rnd_idle got %b/%b exp 0/0", bus.ihit, bus.iREN); end
            tick();
            continue;
         end
         a = ($urandom_range(0, 1) << 28) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         al = a & ~32'h3;
         s = set_of(a);
         exp_hit = mv[s] && (ma[s] == al);
         bus.imemREN = 1'b1; bus.imemaddr = a;
         #1;
         checks++; if (bus.ihit !== exp_hit) begin errors++; $display("FAIL rnd_ihit addr %h got %b exp %b", a, bus.ihit, exp_hit); end
         if (exp_hit) begin
            checks++; if (bus.imemload !== md[s]) begin errors++; $display("FAIL rnd_data addr %h got %h exp %h", a, bus.imemload, md[s]); end
            exp_hits++;
            tick();
            continue;
         end
         exp_miss++;
         tick();
         checks++; if (bus.iREN !== 1'b1 || bus.iaddr !== al) begin errors++; $display("FAIL rnd_fill_req got %b/%h exp 1/%h", bus.iREN, bus.iaddr, al); end
         lat = $urandom_range(0, 3);
         repeat (lat) begin
            if ($urandom_range(0, 1) == 1) begin
               bus.imemaddr = $urandom;
               bus.imemREN  = 1'($urandom_range(0, 1));
            end
            bus.iwait = 1'b1;
            #1;
            checks++; if (bus.ihit !== 1'b0 || bus.iaddr !== al) begin errors++; $display("FAIL rnd_wait got %b/%h exp 0/%h", bus.ihit, bus.iaddr, al); end
            tick();
         end
         bus.iwait = 1'b0; bus.iload = mem_word(al);
         tick();
         bus.iwait = 1'b1;
         model_fill(al, mem_word(al));
      end
      bus.imemREN = 1'b0;
      #1;
`ifdef ICACHE_STATS_EN
      checks++; if (hit_count !== exp_hits) begin errors++; $display("FAIL rnd_hit_count got %0d exp %0d", hit_count, exp_hits); end
      checks++; if (miss_count !== exp_miss) begin errors++; $display("FAIL rnd_miss_count got %0d exp %0d", miss_count, exp_miss); end
`else
      checks++; if (exp_hits == 0 || exp_miss == 0) begin errors++; $display("FAIL rnd_coverage got hits %0d misses %0d exp both nonzero", exp_hits, exp_miss); end
`endif
      tick();
   endtask

`ifdef ICACHE_STATS_EN
   task automatic test_stats();
      apply_reset();
      #1;
      checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL st_reset got %0d/%0d exp 0/0", hit_count, miss_count); end
      bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
      tick();
      serve(3, 32'hDEAD_BEEF);
      tick(); tick(); tick();
      bus.imemREN = 1'b0;
      #1;
      checks++; if (hit_count !== 32'd3) begin errors++; $display("FAIL st_hit_count got %0d exp 3", hit_count); end
      checks++; if (miss_count !== 32'd1) begin errors++; $display("FAIL st_miss_count got %0d exp 1", miss_count); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_first_miss();
      test_hit_and_neighbour();
      test_conflict();
      test_redirect();
      test_reset_mid_fill();
      test_random();
`ifdef ICACHE_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
